instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch front end that produces the opcode stream consumed by the control decoder.
//  - Holds the PC and issues word requests to instruction memory over a valid/ready channel.
//  - Buffers returned instructions and presents them downstream with a valid/ready handshake.
//  - Handles branch redirects, flushing the buffer and discarding stale in-flight responses.
// PARAMETERS
//  XLEN        32            address/PC width
//  RESET_PC    32'h0000_0000 first fetch address after reset
//  IBUF_DEPTH  2             instruction buffer entries, also max requests in flight (power of 2, >=2)
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request this cycle
//  imem_req_addr   out  XLEN  word address of request ([1:0] always 0)
//  imem_rsp_valid  in   1     response valid (in order, >=1 cycle after accept, never back-pressured)
//  imem_rsp_data   in   32    instruction word
//  inst_valid      out  1     buffer head valid
//  inst_ready      in   1     downstream consumes head this cycle
//  inst            out  32    head instruction (0 when !inst_valid)
//  inst_pc         out  XLEN  PC of head instruction
//  opcode          out  7     inst[6:0]; 7'b0000000 when !inst_valid (decodes to all-controls-off)
//  redirect_valid  in   1     branch/jump redirect, single-cycle pulse
//  redirect_pc     in   XLEN  redirect target
//  misalign_err    out  1     sticky: a redirect target had [1:0] != 0
// BEHAVIOUR
//  - Reset (async, any cycle): state=IDLE, pc=RESET_PC, buffer empty, in-flight=0, drop=0;
//    imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=0, opcode=0,
//    inst_pc=RESET_PC, misalign_err=0. Responses arriving after reset are not captured.
//  - FSM: IDLE -> FETCH after one cycle out of reset.
//    FETCH -> DRAIN on redirect while in-flight (after that cycle's accept) > 0.
//    DRAIN -> FETCH when drop count reaches 0.
//    Redirect with nothing in flight stays in FETCH.
//  - Issue (FETCH only): imem_req_valid=1 when in_flight + occupancy < IBUF_DEPTH.
//    Request accepted on valid&ready: pc += 4 (wraps modulo 2^XLEN), in_flight++.
//    addr is held stable while valid&&!ready. The only exception is a redirect, which withdraws
//    the unaccepted request; the next cycle shows the new addr.
//  - Response (FETCH): push {data, pc_of_request} into the buffer; in_flight--.
//    Overflow cannot occur by the credit rule.
//  - Response (DRAIN): discarded; drop--, in_flight--.
//  - Output: head registered in buffer, zero combinational path from imem_rsp to inst.
//    inst/inst_pc/opcode are stable while inst_valid&&!inst_ready. Pop on inst_valid&inst_ready.
//    A push and a pop in the same cycle keep occupancy unchanged.
//    Fetch-to-inst latency: 1 cycle after rsp_valid with the buffer empty.
//  - Redirect (priority over all else in its cycle):
//    - The pop in that cycle still completes (consumer has taken it).
//    - Buffer cleared.
//    - A same-cycle response is discarded.
//    - A same-cycle request accept counts as in flight.
//    - drop = resulting in-flight count.
//    - pc = {redirect_pc[XLEN-1:2],2'b00}.
//    - If redirect_pc[1:0] != 0, set misalign_err (cleared only by reset).
//    - No requests issue in DRAIN.
//    - A second redirect in DRAIN updates pc only; drop already covers all in-flight responses.
//  - Occupancy and in-flight counters saturate-checked by assertion: never exceed IBUF_DEPTH.
// TESTING
//  1. Reset, ready=1, rsp 1 cycle latency, inst_ready=1 -> requests at 0x0,0x4,0x8,...
//     inst_pc follows the same sequence; opcode = rsp[6:0].
//  2. inst_ready=0 for 10 cycles -> exactly 2 requests issued.
//     inst/inst_pc held at 0x0 data; resume -> 0x4 follows with no loss.
//  3. Redirect to 0x100 with 2 in flight -> both stale rsps dropped.
//     The first inst_valid shows inst_pc=0x100; no request issues until the drains complete.
//  4. Redirect coincident with rsp_valid and inst_valid&inst_ready -> head consumed.
//     rsp dropped; next inst_pc=target.
//  5. imem_req_ready=0 for 5 cycles -> addr stable at 0x8.
//     Redirect to 0x203 -> addr becomes 0x200; misalign_err=1 sticky until rst_n low.
//  6. pc=0xFFFF_FFFC accepted -> next addr 0x0.
//     Assert rst_n=0 mid-flight -> all outputs at reset values immediately.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory request/response channel,
// the buffered instruction stream handed to the decoder, and the branch redirect input.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [6:0]      opcode;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign_err;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    output opcode,
    input  redirect_valid,
    input  redirect_pc,
    output misalign_err
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    input  opcode,
    output redirect_valid,
    output redirect_pc,
    input  misalign_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited memory requests, in-order instruction
// buffer feeding the decoder, and branch redirect with stale-response draining.
module instr_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IBUF_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(IBUF_DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(IBUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   in_flight_q, in_flight_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            misalign_q, misalign_d;

  logic [31:0]     buf_data_q [IBUF_DEPTH];
  logic [XLEN-1:0] buf_pc_q   [IBUF_DEPTH];

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_ack;
  logic            push;
  logic            pop;
  logic            head_valid;
  logic [31:0]     head_inst;
  logic [XLEN-1:0] rsp_pc;

  assign credit_used = {1'b0, in_flight_q} + {1'b0, occ_q};
  assign req_fire    = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_ack     = bus.imem_rsp_valid && (in_flight_q != '0);
  assign push        = rsp_ack && (state_q == FETCH) && !bus.redirect_valid;
  assign head_valid  = (occ_q != '0);
  assign pop         = head_valid && bus.inst_ready;
  assign head_inst   = head_valid ? buf_data_q[rd_ptr_q] : 32'h0;

  // In FETCH every outstanding request is consecutive and ends at pc-4, so the
  // oldest one (the response now arriving) sits in_flight words behind pc.
  assign rsp_pc = pc_q - (XLEN'(in_flight_q) << 2);

  assign bus.imem_req_valid = (state_q == FETCH) && (credit_used < DEPTH_EXT);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = head_valid;
  assign bus.inst           = head_inst;
  assign bus.opcode         = head_inst[6:0];
  assign bus.inst_pc        = buf_pc_q[rd_ptr_q];
  assign bus.misalign_err   = misalign_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    in_flight_d = in_flight_q + CW'(req_fire) - CW'(rsp_ack);
    occ_d       = occ_q + CW'(push) - CW'(pop);
    drop_d      = drop_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    misalign_d  = misalign_q;

    if (req_fire) begin
      pc_d = pc_q + XLEN'(4);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if ((state_q == DRAIN) && rsp_ack) begin
      drop_d = drop_q - CW'(1);
    end

    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      DRAIN:   state_d = (drop_d == '0) ? FETCH : DRAIN;
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything above except the in-flight accounting:
    // whatever is still outstanding afterwards must be dropped on return.
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[XLEN-1:2], 2'b00};
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = in_flight_d;
      state_d  = (in_flight_d != '0) ? DRAIN : FETCH;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      in_flight_q <= '0;
      occ_q       <= '0;
      drop_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      in_flight_q <= in_flight_d;
      occ_q       <= occ_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      misalign_q  <= misalign_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= RESET_PC;
      end
    end else if (push) begin
      buf_data_q[wr_ptr_q] <= bus.imem_rsp_data;
      buf_pc_q[wr_ptr_q]   <= rsp_pc;
    end
  end

  // The credit rule alone keeps both counters bounded.
  assert property (@(posedge clk) disable iff (!rst_n)
    (occ_q <= DEPTH_CNT) && (in_flight_q <= DEPTH_CNT) && (credit_used <= DEPTH_EXT));

  assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ((occ_q < DEPTH_CNT) || pop));

endmodule
